// File: rtl/pe_sched_pkg.sv
// Shared definitions for the pe_scheduler slice: FSM state encoding,
// default sizing constants and an index-width helper.
package pe_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } pe_state_e;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_C       = 16;
  localparam int DEF_W_X     = 32;
  localparam int DEF_W_K     = 32;
  localparam int DEF_TIMEOUT = 64;

  // Width of an index into n items; a single item still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pe_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin pick of one request, searching upward from ptr
// with wrap-around; returns a one-hot grant and its index.
module rr_arbiter
  import pe_sched_pkg::*;
#(
  parameter int N  = DEF_NREQ,
  parameter int IW = idx_width(DEF_NREQ)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  // Smallest rotational distance from ptr among active requests wins.
  always_comb begin
    int dist_s;
    int best_s;
    dist_s    = 0;
    best_s    = N;
    grant_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (k >= int'(ptr)) begin
        dist_s = k - int'(ptr);
      end else begin
        dist_s = k + N - int'(ptr);
      end
      if (req[k] && (dist_s < best_s)) begin
        best_s    = dist_s;
        grant_idx = IW'(k);
      end else begin
        best_s    = best_s;
      end
    end
    grant_any = (best_s < N);
    if (grant_any) begin
      grant = N'(1'b1) << grant_idx;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/pe_scheduler.sv
// pe_scheduler: shares one processing element between NREQ requesters, one job
// at a time. Optional RUN watchdog is enabled by defining PE_SCHED_TIMEOUT_EN.
module pe_scheduler
  import pe_sched_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int C       = DEF_C,
  parameter int W_X     = DEF_W_X,
  parameter int W_K     = DEF_W_K,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NREQ-1:0]                  req_valid,
  output logic [NREQ-1:0]                  req_ready,
  input  logic [NREQ-1:0][C-1:0][W_X-1:0]  req_x,
  input  logic [NREQ-1:0][C-1:0][W_K-1:0]  req_k,
  output logic [NREQ-1:0]                  resp_valid,
  input  logic [NREQ-1:0]                  resp_ready,
  output logic [W_X-1:0]                   resp_data,
  output logic                             resp_err,
  output logic                             pe_enable,
  output logic [C-1:0][W_X-1:0]            pe_x,
  output logic [C-1:0][W_K-1:0]            pe_k,
  input  logic [W_X-1:0]                   pe_y_out,
  input  logic                             pe_v_valid,
  output logic                             busy
);

  localparam int IW = idx_width(NREQ);

  if (NREQ < 1 || TIMEOUT < 1) begin : g_param_check
    $error("pe_scheduler: NREQ and TIMEOUT must be at least 1");
  end

  pe_state_e               state_r, state_s;
  logic [IW-1:0]           ptr_r, gidx_r, arb_idx_s;
  logic [NREQ-1:0]         arb_grant_s, resp_valid_r;
  logic                    arb_any_s, accept_s, done_s, tmo_s, rel_s, timeout_hit_s;
  logic                    pe_enable_r, busy_r;
  logic [W_X-1:0]          resp_data_r;
  logic [C-1:0][W_X-1:0]   pe_x_r;
  logic [C-1:0][W_K-1:0]   pe_k_r;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_r),
    .grant     (arb_grant_s),
    .grant_idx (arb_idx_s),
    .grant_any (arb_any_s)
  );

  // Grant is only offered in IDLE and never while reset is held.
  assign accept_s  = (state_r == IDLE) && arb_any_s;
  assign req_ready = (rst_n && accept_s) ? arb_grant_s : '0;

  // Next-state decode for the single outstanding job.
  always_comb begin
    state_s = state_r;
    done_s  = 1'b0;
    tmo_s   = 1'b0;
    rel_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (arb_any_s) state_s = RUN;
        else           state_s = IDLE;
      end
      RUN: begin
        if (pe_v_valid) begin
          done_s  = 1'b1;
          state_s = RESP;
        end else if (timeout_hit_s) begin
          tmo_s   = 1'b1;
          state_s = RESP;
        end else begin
          state_s = RUN;
        end
      end
      RESP: begin
        if (resp_ready[gidx_r]) begin
          rel_s   = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Control registers: state, owner, round-robin pointer, enable and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      gidx_r      <= '0;
      pe_enable_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      pe_enable_r <= (state_s == RUN);
      busy_r      <= (state_s != IDLE);
      if (accept_s) gidx_r <= arb_idx_s;
      if (rel_s) ptr_r <= (gidx_r == IW'(NREQ - 1)) ? '0 : gidx_r + IW'(1);
    end
  end

  // Operand capture on grant; held through RUN and RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_x_r <= '0;
      pe_k_r <= '0;
    end else if (accept_s) begin
      pe_x_r <= req_x[arb_idx_s];
      pe_k_r <= req_k[arb_idx_s];
    end
  end

  // Response registers, held stable until the owner accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_r <= '0;
      resp_data_r  <= '0;
    end else if (done_s || tmo_s) begin
      resp_valid_r <= NREQ'(1'b1) << gidx_r;
      resp_data_r  <= done_s ? pe_y_out : '0;
    end else if (rel_s) begin
      resp_valid_r <= '0;
    end
  end

`ifdef PE_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt_r;
  logic          resp_err_r;

  assign timeout_hit_s = (state_r == RUN) && (tmo_cnt_r == CW'(TIMEOUT - 1));

  // Watchdog: counts RUN cycles, restarted on every accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r  <= '0;
      resp_err_r <= 1'b0;
    end else begin
      if (accept_s) tmo_cnt_r <= '0;
      else if ((state_r == RUN) && !timeout_hit_s) tmo_cnt_r <= tmo_cnt_r + CW'(1);
      if (done_s) resp_err_r <= 1'b0;
      else if (tmo_s) resp_err_r <= 1'b1;
    end
  end

  assign resp_err = resp_err_r;
`else
  assign timeout_hit_s = 1'b0;
  assign resp_err      = 1'b0;
`endif

  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;
  assign pe_enable  = pe_enable_r;
  assign pe_x       = pe_x_r;
  assign pe_k       = pe_k_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_pe_scheduler.sv
// Self-checking bench for pe_scheduler: behavioural PE stub, round-robin
// reference model and directed plus randomized job sequences.
module tb_pe_scheduler;

  localparam int NREQ = 4;
  localparam int C    = 16;
  localparam int W    = 32;
  localparam int TO   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          rst_n;
  logic [NREQ-1:0]               req_valid, req_ready, resp_valid, resp_ready;
  logic [NREQ-1:0][C-1:0][W-1:0] req_x, req_k;
  logic [W-1:0]                  resp_data, pe_y_out;
  logic                          resp_err, pe_enable, pe_v_valid, busy;
  logic [C-1:0][W-1:0]           pe_x, pe_k;

  int checks   = 0;
  int failures = 0;
  int exp_ptr  = 0;
  int pe_lat   = 0;
  int pe_cnt   = 0;
  bit pe_hang  = 1'b0;
  bit spur     = 1'b0;
  logic [W-1:0] last_exp_d = '0;

  pe_scheduler #(.NREQ(NREQ), .C(C), .W_X(W), .W_K(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_k(req_k),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err), .pe_enable(pe_enable), .pe_x(pe_x), .pe_k(pe_k),
    .pe_y_out(pe_y_out), .pe_v_valid(pe_v_valid), .busy(busy)
  );

  function automatic logic [W-1:0] dot(input logic [C-1:0][W-1:0] a, input logic [C-1:0][W-1:0] b);
    logic [W-1:0] acc;
    acc = '0;
    for (int i = 0; i < C; i++) acc = acc + a[i] * b[i];
    return acc;
  endfunction

  // PE stub: result ready pe_lat cycles after enable rises, cleared when enable drops.
  always @(posedge clk) begin
    if (!pe_enable) pe_cnt <= 0;
    else            pe_cnt <= pe_cnt + 1;
  end
  assign pe_v_valid = spur | (pe_enable & ~pe_hang & (pe_cnt == pe_lat));
  assign pe_y_out   = spur ? 32'hDEAD_BEEF : dot(pe_x, pe_k);

  // Reference arbitration: first valid requester at or after the pointer, wrapping.
  function automatic int model_grant(input logic [NREQ-1:0] v, input int p);
    for (int i = 0; i < NREQ; i++)
      if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, '0);
    chk({tag, "_resp_valid"}, resp_valid, '0);
    chk({tag, "_resp_data"}, resp_data, '0);
    chk({tag, "_resp_err"}, resp_err, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_pe_enable"}, pe_enable, 1'b0);
    chk({tag, "_pe_xk_zero"}, (pe_x === '0) && (pe_k === '0), 1'b1);
  endtask

  // One complete job from grant in IDLE to response handshake back to IDLE.
  task automatic do_job(input int lat, input int bp, input logic [NREQ-1:0] extra, output int g);
    logic [NREQ-1:0]     oh;
    logic [W-1:0]        exp_d;
    logic [C-1:0][W-1:0] ex, ek;
    int runs;
    pe_lat  = lat;
    pe_hang = 1'b0;
    #1;
    g  = model_grant(req_valid, exp_ptr);
    oh = NREQ'(1) << g;
    chk("req_ready_grant", req_ready, oh);
    chk("pe_enable_idle", pe_enable, 1'b0);
    exp_d = dot(req_x[g], req_k[g]);
    ex    = req_x[g];
    ek    = req_k[g];
    step();
    chk("busy_run", busy, 1'b1);
    chk("req_ready_run", req_ready, '0);
    chk("pe_enable_run", pe_enable, 1'b1);
    chk("pe_xk_latched", (pe_x === ex) && (pe_k === ek), 1'b1);
    runs = 0;
    while (resp_valid == '0 && runs < lat + 4) begin
      runs++;
      step();
    end
    chk("run_cycles", runs, lat + 1);
    chk("resp_valid_owner", resp_valid, oh);
    chk("resp_data", resp_data, exp_d);
    chk("resp_err", resp_err, 1'b0);
    chk("pe_enable_resp", pe_enable, 1'b0);
    for (int i = 0; i < bp; i++) begin
      resp_ready = extra & ~oh;
      step();
      chk("bp_resp_valid", resp_valid, oh);
      chk("bp_resp_data", resp_data, exp_d);
      chk("bp_pe_enable", pe_enable, 1'b0);
      chk("bp_req_ready", req_ready, '0);
    end
    resp_ready = oh | extra;
    step();
    resp_ready = '0;
    chk("resp_released", resp_valid, '0);
    chk("busy_idle", busy, 1'b0);
    chk("pe_xk_after", (pe_x === ex) && (pe_k === ek), 1'b1);
    exp_ptr    = (g + 1) % NREQ;
    last_exp_d = exp_d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int runs;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    rst_n      = 1'b0;
    req_valid  = '1;
    resp_ready = '0;
    req_x      = '0;
    req_k      = '0;
    #2;
    check_reset_outputs("reset");
    step();
    step();
    req_valid = '0;
    rst_n     = 1'b1;
    exp_ptr   = 0;
    step();

    // Single job on requester 2: x = 3, k = 2 across all lanes.
    for (int c = 0; c < C; c++) begin
      req_x[2][c] = 32'd3;
      req_k[2][c] = 32'd2;
    end
    req_valid = 4'b0100;
    do_job(2, 0, '0, g);
    chk("single_grant_idx", g, 2);
    chk("single_dot", last_exp_d, 32'd96);
    req_valid = '0;

    // Contention from reset with every requester asking.
    rst_n = 1'b0;
    step();
    rst_n   = 1'b1;
    exp_ptr = 0;
    for (int r = 0; r < NREQ; r++)
      for (int c = 0; c < C; c++) begin
        req_x[r][c] = $urandom;
        req_k[r][c] = $urandom;
      end
    req_valid = '1;
    for (int n = 0; n < 5; n++) begin
      do_job($urandom_range(0, 4), 0, '0, g);
      chk("contention_order", g, exp_order[n]);
    end

    // Backpressure: owner holds resp_ready low for 10 cycles.
    req_valid = 4'b0010;
    do_job(1, 10, 4'b1101, g);
    chk("bp_grant_idx", g, 1);
    req_valid = '0;

    // Reset during RUN: no response, pointer back to requester 0.
    req_valid = 4'b1000;
    pe_hang   = 1'b1;
    #1;
    chk("midrun_grant", req_ready, 4'b1000);
    step();
    for (int i = 0; i < 4; i++) step();
    chk("midrun_still_running", pe_enable, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun");
    req_valid = '1;
    #1;
    chk("midrun_ready_in_reset", req_ready, '0);
    step();
    step();
    chk("midrun_no_resp", resp_valid, '0);
    rst_n   = 1'b1;
    exp_ptr = 0;
    #1;
    chk("grant_after_reset", req_ready, 4'b0001);
    do_job(0, 1, '0, g);
    req_valid = '0;

    // Spurious PE valid and unsolicited resp_ready while IDLE.
    step();
    spur = 1'b1;
    step();
    spur = 1'b0;
    chk("spur_busy", busy, 1'b0);
    chk("spur_resp_valid", resp_valid, '0);
    chk("spur_pe_enable", pe_enable, 1'b0);
    resp_ready = '1;
    step();
    resp_ready = '0;
    chk("spur_resp_data_held", resp_data, last_exp_d);
    chk("spur_resp_valid2", resp_valid, '0);

    // Randomized jobs against the reference model.
    for (int n = 0; n < 20; n++) begin
      for (int r = 0; r < NREQ; r++)
        for (int c = 0; c < C; c++) begin
          req_x[r][c] = $urandom;
          req_k[r][c] = $urandom;
        end
      req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      do_job($urandom_range(0, 5), $urandom_range(0, 3), NREQ'($urandom), g);
    end
    req_valid = '0;

`ifdef PE_SCHED_TIMEOUT_EN
    // Watchdog: PE never answers.
    step();
    req_valid = 4'b0001 << exp_ptr;
    pe_hang   = 1'b1;
    #1;
    g = model_grant(req_valid, exp_ptr);
    step();
    req_valid = '0;
    runs = 0;
    while (pe_enable && runs < TO + 4) begin
      runs++;
      step();
    end
    chk("tmo_run_cycles", runs, TO);
    chk("tmo_resp_valid", resp_valid, NREQ'(1) << g);
    chk("tmo_resp_data", resp_data, '0);
    chk("tmo_resp_err", resp_err, 1'b1);
    resp_ready = NREQ'(1) << g;
    step();
    resp_ready = '0;
    chk("tmo_released", resp_valid, '0);
    pe_hang = 1'b0;
`else
    runs = 0;
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_scheduler.md
PE_SCHEDULER -- requirements
Module: pe_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one PE.
REQ-002 SHALL have parameter C, default 16: vector length, matches PE.
REQ-003 SHALL have parameters W_X and W_K, defaults 32 and 32: element widths, match PE.
REQ-004 SHALL have parameter TIMEOUT, default 64: watchdog limit in cycles.
REQ-005 SHALL have port clk, in, 1: single clock; all state on posedge.
REQ-006 SHALL have port rst_n, in, 1: reset, asynchronous, active-low.
REQ-007 SHALL have ports req_valid and req_ready, in and out, [NREQ]: per-requester job handshake.
REQ-008 SHALL have ports req_x and req_k, in, [NREQ][C][W_X] and [NREQ][C][W_K]: operand vectors.
REQ-009 SHALL have ports resp_valid and resp_ready, out and in, [NREQ]: per-requester result handshake.
REQ-010 SHALL have port resp_data, out, W_X: result, shared by all requesters.
REQ-011 SHALL have port resp_err, out, 1: timeout flag, qualified by resp_valid.
REQ-012 SHALL have port pe_enable, out, 1: drives the PE enable input; low clears the PE asynchronously.
REQ-013 SHALL have ports pe_x and pe_k, out, [C][W_X] and [C][W_K]: registered operands to the PE.
REQ-014 SHALL have ports pe_y_out and pe_v_valid, in, W_X and 1: PE result and PE valid.
REQ-015 SHALL have port busy, out, 1: high whenever state is not IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN and RESP; at most one job is outstanding.
REQ-017 IDLE: pe_enable=0; if any req_valid, SHALL grant one requester g by round-robin, assert req_ready[g] combinationally in the same cycle, latch req_x[g]/req_k[g] into pe_x/pe_k, latch g, and go to RUN.
REQ-018 Round-robin: search SHALL start at pointer p and proceed through p, p+1, ... mod NREQ; p = g+1 mod NREQ after the response handshake.
REQ-019 RUN: pe_enable=1 from the first RUN cycle; pe_x/pe_k SHALL be held stable; req_ready SHALL be all zero.
REQ-020 RUN: on a cycle with pe_v_valid=1, SHALL register pe_y_out into resp_data, set resp_err=0, drive pe_enable=0 from the next cycle, and go to RESP.
REQ-021 RESP: resp_valid[g]=1 only, from the cycle after pe_v_valid is sampled; resp_data and resp_err held until resp_ready[g]=1, then go to IDLE.
REQ-022 pe_v_valid outside RUN, resp_ready while resp_valid is low, and req_valid outside IDLE SHALL be ignored.
REQ-023 Between consecutive jobs, pe_enable SHALL be low for at least 2 cycles (RESP plus IDLE), guaranteeing a PE clear.
REQ-024 Minimum turnaround SHALL be: accept, 1 RUN cycle per PE latency, 1 RESP cycle, 1 IDLE cycle; back-to-back requests alternate fairly.

Reset
REQ-025 While rst_n=0, SHALL set: state IDLE, p=0, pe_enable=0, pe_x/pe_k=0, resp_valid=0, resp_data=0, resp_err=0, busy=0, req_ready=0.
REQ-026 Reset mid-job SHALL abort the job with no response; after reset, requesters must re-present.

Configuration
REQ-027 With PE_SCHED_TIMEOUT_EN defined, SHALL count cycles in RUN and, on reaching TIMEOUT without pe_v_valid, go to RESP with resp_data=0 and resp_err=1; pe_v_valid arriving in the same cycle takes priority.
REQ-028 Without PE_SCHED_TIMEOUT_EN, resp_err SHALL be tied 0, no counter SHALL exist, and RUN SHALL wait indefinitely.

Structure
REQ-029 Package pe_sched_pkg SHALL hold the state enum (IDLE, RUN, RESP) and default parameter constants.
REQ-030 Round-robin grant SHALL be a sub-module rr_arbiter (inputs: request vector and pointer; output: one-hot grant plus index).

Verification
REQ-031 Single job: NREQ=4, req 2 valid, x=all 3, k=all 2, with the real PE (C=16) -> req_ready[2] in the same cycle, resp_valid[2] with resp_data=96 and resp_err=0.
REQ-032 Contention: all four req_valid held high from reset -> grant order 0,1,2,3,0 and no resp_valid on any non-granted index.
REQ-033 Backpressure: resp_ready[g] held low for 10 cycles -> resp_valid and resp_data stable; pe_enable=0; no new req_ready.
REQ-034 Reset mid-RUN: rst_n low at cycle 5 of RUN -> every output equals its reset value immediately, no response, next grant goes to requester 0.
REQ-035 Timeout (macro on, TIMEOUT=8): PE stub never asserts pe_v_valid -> after 8 RUN cycles, resp_valid with resp_data=0 and resp_err=1.
REQ-036 Spurious pe_v_valid pulse in IDLE -> no state change and no resp_valid.
